// File: rtl/memstage_sized.sv
// Load/store memory stage: byte/half/word/(dword) access over a single-port word RAM,
// with sign/zero extension on loads, alignment checking and RMW sequencing for sub-word stores.
module memstage_sized #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned OFF   = (DATA_WIDTH == 64) ? 3 : 2;
  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [1:0]  FULL_SIZE = (DATA_WIDTH == 64) ? 2'b11 : 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_LD, S_RMW} state_e;

  state_e                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              size_q, size_d;
  logic                    sgn_q, sgn_d;
  logic [OFF-1:0]          lane_q, lane_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_q;
  logic                    mem_we_c, mem_re_c;
  logic [DEPTH_LOG2-1:0]   mem_idx_c;
  logic [DATA_WIDTH-1:0]   mem_wdata_c;

  logic [DEPTH_LOG2-1:0]   req_idx_c;
  logic [OFF-1:0]          req_lane_c;
  logic                    req_err_c;
  logic                    unused_c;

  logic [NB-1:0]           bmask_c;
  logic [DATA_WIDTH-1:0]   wsh_c, merged_c, rsh_c, keep_c, ext_c;
  logic                    sbit_c;
  int                      lo_c, nbytes_c;

  // Upper address bits wrap away; RAM index and lane come from the low bits.
  assign req_idx_c  = req_addr[DEPTH_LOG2+OFF-1:OFF];
  assign req_lane_c = req_addr[OFF-1:0];
  assign unused_c   = ^req_addr[ADDR_WIDTH-1:DEPTH_LOG2+OFF];

  always_comb begin
    req_err_c = 1'b0;
    case (req_size)
      2'b00:   req_err_c = 1'b0;
      2'b01:   req_err_c = req_addr[0];
      2'b10:   req_err_c = |req_addr[1:0];
      default: req_err_c = (DATA_WIDTH != 64) || (|req_addr[2:0]);
    endcase
  end

  // Lane merge for RMW stores and lane extract/extend for loads, from captured fields.
  always_comb begin
    lo_c     = int'(lane_q);
    nbytes_c = 1;
    case (size_q)
      2'b00:   nbytes_c = 1;
      2'b01:   nbytes_c = 2;
      2'b10:   nbytes_c = 4;
      default: nbytes_c = 8;
    endcase
    wsh_c    = wdata_q << {lane_q, 3'b000};
    bmask_c  = '0;
    merged_c = rd_q;
    for (int b = 0; b < int'(NB); b++) begin
      bmask_c[b] = (b >= lo_c) && (b < lo_c + nbytes_c);
      if (bmask_c[b]) merged_c[8*b +: 8] = wsh_c[8*b +: 8];
    end
    rsh_c  = rd_q >> {lane_q, 3'b000};
    keep_c = '1;
    sbit_c = rsh_c[DATA_WIDTH-1];
    case (size_q)
      2'b00:   begin keep_c = DATA_WIDTH'(8'hFF);         sbit_c = rsh_c[7];  end
      2'b01:   begin keep_c = DATA_WIDTH'(16'hFFFF);      sbit_c = rsh_c[15]; end
      2'b10:   begin keep_c = DATA_WIDTH'(32'hFFFF_FFFF); sbit_c = rsh_c[31]; end
      default: begin keep_c = '1;                         sbit_c = rsh_c[DATA_WIDTH-1]; end
    endcase
    ext_c = (rsh_c & keep_c) | ({DATA_WIDTH{sgn_q & sbit_c}} & ~keep_c);
  end

  // Next-state and RAM control.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    size_d      = size_q;
    sgn_d       = sgn_q;
    lane_d      = lane_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    mem_we_c    = 1'b0;
    mem_re_c    = 1'b0;
    mem_idx_c   = req_idx_c;
    mem_wdata_c = req_wdata;
    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          size_d  = req_size;
          sgn_d   = req_signed;
          lane_d  = req_lane_c;
          idx_d   = req_idx_c;
          wdata_d = req_wdata;
          if (req_err_c) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_we && (req_size == FULL_SIZE)) begin
            mem_we_c    = 1'b1;
            rsp_valid_d = 1'b1;
          end else begin
            mem_re_c = 1'b1;
            state_d  = req_we ? S_RMW : S_LD;
          end
        end
      end
      S_LD: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ext_c;
        state_d     = S_IDLE;
      end
      S_RMW: begin
        mem_we_c    = 1'b1;
        mem_idx_c   = idx_q;
        mem_wdata_c = merged_c;
        rsp_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      lane_q      <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      lane_q      <= lane_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
    end
  end

  // Word RAM: contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_idx_c] <= mem_wdata_c;
    if (mem_re_c) rd_q <= mem[mem_idx_c];
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_memstage_sized.sv
// Scoreboard bench for memstage_sized: 32-bit default build and a 64-bit/16-word build.
module tb_memstage_sized;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32_n, v32, rdy32, we32, sgn32, rv32, err32;
  logic [1:0]  sz32;
  logic [31:0] a32, wd32, rd32;

  logic        rst64_n, v64, rdy64, we64, sgn64, rv64, err64;
  logic [1:0]  sz64;
  logic [31:0] a64;
  logic [63:0] wd64, rd64;

  memstage_sized #(.DATA_WIDTH(32), .DEPTH_LOG2(10), .ADDR_WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst32_n), .req_valid(v32), .req_ready(rdy32), .req_we(we32),
    .req_size(sz32), .req_signed(sgn32), .req_addr(a32), .req_wdata(wd32),
    .rsp_valid(rv32), .rsp_rdata(rd32), .rsp_err(err32));

  memstage_sized #(.DATA_WIDTH(64), .DEPTH_LOG2(4), .ADDR_WIDTH(32)) u_dut64 (
    .clk(clk), .rst_n(rst64_n), .req_valid(v64), .req_ready(rdy64), .req_we(we64),
    .req_size(sz64), .req_signed(sgn64), .req_addr(a64), .req_wdata(wd64),
    .rsp_valid(rv64), .rsp_rdata(rd64), .rsp_err(err64));

  typedef struct {
    logic        err;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare whenever a response pulse is seen.
  always @(negedge clk) begin
    exp_t e;
    if (rv32 === 1'b1) begin
      if (q32.size() == 0) chk("rsp32_unexpected", 64'd1, 64'd0);
      else begin
        e = q32.pop_front();
        chk("rsp32_data", 64'(rd32), e.data);
        chk("rsp32_err", 64'(err32), 64'(e.err));
        chk("rsp32_latency", 64'(cyc), 64'(e.cyc));
      end
    end
    if (rv64 === 1'b1) begin
      if (q64.size() == 0) chk("rsp64_unexpected", 64'd1, 64'd0);
      else begin
        e = q64.pop_front();
        chk("rsp64_data", rd64, e.data);
        chk("rsp64_err", 64'(err64), 64'(e.err));
        chk("rsp64_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Issue one request on instance sel (0 = 32-bit, 1 = 64-bit) and queue its expected response.
  task automatic do_req(input bit sel, input bit we, input logic [1:0] size, input bit sgn,
                        input logic [31:0] addr, input logic [63:0] wdata,
                        input bit eerr, input logic [63:0] edata);
    exp_t e;
    int   n;
    bit   full;
    @(negedge clk);
    if (!sel) begin
      v32 = 1'b1; we32 = we; sz32 = size; sgn32 = sgn; a32 = addr; wd32 = wdata[31:0];
    end else begin
      v64 = 1'b1; we64 = we; sz64 = size; sgn64 = sgn; a64 = addr; wd64 = wdata;
    end
    n = 0;
    while (!(sel ? rdy64 : rdy32) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk("ready_timeout", 64'd0, 64'd1);
      v32 = 1'b0; v64 = 1'b0;
      return;
    end
    full   = we && (sel ? (size == 2'b11) : (size == 2'b10));
    e.err  = eerr;
    e.data = edata;
    e.cyc  = cyc + ((eerr || full) ? 1 : 2);
    if (!sel) q32.push_back(e);
    else      q64.push_back(e);
    @(posedge clk);
    #1;
    v32 = 1'b0;
    v64 = 1'b0;
  endtask

  initial begin
    rst32_n = 1'b0; rst64_n = 1'b0;
    v32 = 1'b0; we32 = 1'b0; sz32 = 2'b00; sgn32 = 1'b0; a32 = '0; wd32 = '0;
    v64 = 1'b0; we64 = 1'b0; sz64 = 2'b00; sgn64 = 1'b0; a64 = '0; wd64 = '0;
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid32", 64'(rv32), 64'd0);
    chk("reset_rdata32", 64'(rd32), 64'd0);
    chk("reset_err32", 64'(err32), 64'd0);
    chk("reset_rsp_valid64", 64'(rv64), 64'd0);
    rst32_n = 1'b1; rst64_n = 1'b1;
    #1;
    chk("ready_after_reset32", 64'(rdy32), 64'd1);
    chk("ready_after_reset64", 64'(rdy64), 64'd1);

    // Full word store then load, then RMW byte and half.
    do_req(0, 1, 2'b10, 0, 32'h10, 64'hDEADBEEF, 0, 64'h0);
    do_req(0, 0, 2'b10, 0, 32'h10, 64'h0,        0, 64'hDEADBEEF);
    do_req(0, 1, 2'b00, 0, 32'h11, 64'h5A,       0, 64'h0);
    do_req(0, 0, 2'b10, 0, 32'h10, 64'h0,        0, 64'hDEAD5AEF);
    do_req(0, 1, 2'b01, 0, 32'h12, 64'h1234,     0, 64'h0);
    do_req(0, 0, 2'b10, 0, 32'h10, 64'h0,        0, 64'h12345AEF);

    // Extension.
    do_req(0, 1, 2'b10, 0, 32'h20, 64'h000080F0, 0, 64'h0);
    do_req(0, 0, 2'b00, 1, 32'h20, 64'h0,        0, 64'hFFFFFFF0);
    do_req(0, 0, 2'b00, 0, 32'h20, 64'h0,        0, 64'h000000F0);
    do_req(0, 0, 2'b01, 1, 32'h20, 64'h0,        0, 64'hFFFF80F0);
    do_req(0, 0, 2'b01, 0, 32'h20, 64'h0,        0, 64'h000080F0);
    do_req(0, 0, 2'b00, 1, 32'h21, 64'h0,        0, 64'hFFFFFF80);

    // Errors leave the RAM untouched.
    do_req(0, 0, 2'b01, 1, 32'h21, 64'h0,        1, 64'h0);
    do_req(0, 1, 2'b10, 0, 32'h22, 64'hFFFFFFFF, 1, 64'h0);
    do_req(0, 0, 2'b11, 0, 32'h20, 64'h0,        1, 64'h0);
    do_req(0, 1, 2'b11, 0, 32'h20, 64'hFFFFFFFF, 1, 64'h0);
    do_req(0, 0, 2'b10, 0, 32'h20, 64'h0,        0, 64'h000080F0);

    // Address 2^12 + 0x10 aliases word 4.
    do_req(0, 0, 2'b10, 0, 32'h1010, 64'h0,      0, 64'h12345AEF);

    // Reset in the RMW cycle abandons the write.
    do_req(0, 1, 2'b10, 0, 32'h30, 64'h11223344, 0, 64'h0);
    @(negedge clk);
    v32 = 1'b1; we32 = 1'b1; sz32 = 2'b00; sgn32 = 1'b0; a32 = 32'h30; wd32 = 32'hAA;
    chk("ready_before_rmw", 64'(rdy32), 64'd1);
    @(posedge clk);
    #1;
    v32 = 1'b0;
    chk("ready_in_rmw", 64'(rdy32), 64'd0);
    rst32_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 64'(rv32), 64'd0);
    chk("midrst_rdata", 64'(rd32), 64'd0);
    chk("midrst_err", 64'(err32), 64'd0);
    repeat (2) @(negedge clk);
    rst32_n = 1'b1;
    #1;
    chk("ready_after_midrst", 64'(rdy32), 64'd1);
    do_req(0, 0, 2'b10, 0, 32'h30, 64'h0,        0, 64'h11223344);

    // 64-bit build: doubleword, sub-word loads, wrap and RMW.
    do_req(1, 1, 2'b11, 0, 32'h08, 64'h0123456789ABCDEF, 0, 64'h0);
    do_req(1, 0, 2'b00, 0, 32'h0F, 64'h0, 0, 64'h01);
    do_req(1, 0, 2'b10, 1, 32'h0C, 64'h0, 0, 64'h0000000001234567);
    do_req(1, 0, 2'b10, 1, 32'h08, 64'h0, 0, 64'hFFFFFFFF89ABCDEF);
    do_req(1, 0, 2'b01, 0, 32'h0A, 64'h0, 0, 64'h00000000000089AB);
    do_req(1, 1, 2'b11, 0, 32'h88, 64'hCAFEF00D12345678, 0, 64'h0);
    do_req(1, 0, 2'b11, 0, 32'h08, 64'h0, 0, 64'hCAFEF00D12345678);
    do_req(1, 0, 2'b11, 0, 32'h0C, 64'h0, 1, 64'h0);
    do_req(1, 1, 2'b00, 0, 32'h0D, 64'h77, 0, 64'h0);
    do_req(1, 0, 2'b11, 0, 32'h08, 64'h0, 0, 64'hCAFE770D12345678);

    for (int i = 0; i < 20 && (q32.size() != 0 || q64.size() != 0); i++) @(negedge clk);
    chk("q32_drained", 64'(q32.size()), 64'd0);
    chk("q64_drained", 64'(q64.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memstage_sized.md
# memstage_sized

Parametrised load/store memory stage with byte, halfword, word and (64-bit builds) doubleword access, sign/zero extension on loads and alignment checking. It replaces the fixed word/byte memory stage in the datapath, sitting between the ALU address result and writeback. Sub-word stores run as a read-modify-write on an internal single-port word RAM, sequenced by a small state machine, with a valid/ready request side and a one-cycle response pulse.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: word width. Legal values are 32 and 64.
- `DEPTH_LOG2`, default 10: RAM holds 2^DEPTH_LOG2 words.
- `ADDR_WIDTH`, default 32: byte address width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  stage can accept. High only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  access size: 00 byte, 01 half, 10 word (32 bits), 11 doubleword (64 bits; only legal when DATA_WIDTH = 64).
- `req_signed`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  DATA_WIDTH  store data, right-aligned (LSBs used).
- `rsp_valid`  out  1  single-cycle completion pulse.
- `rsp_rdata`  out  DATA_WIDTH  load result, right-aligned and extended. 0 for stores and errors.
- `rsp_err`  out  1  qualifies `rsp_valid`: access was misaligned or had an illegal size.

## Operation
Addressing:
- OFF = log2(DATA_WIDTH/8).
- Word index = `req_addr[DEPTH_LOG2+OFF-1:OFF]`. Upper address bits are ignored, so addresses wrap modulo the RAM size.
- Lane = `req_addr[OFF-1:0]`. Byte order is little-endian.

Alignment:
- Byte: always aligned.
- Half: requires addr[0] = 0.
- Word: requires addr[1:0] = 0.
- Doubleword: requires addr[2:0] = 0.
- `req_size` = 11 with DATA_WIDTH = 32 is illegal.
- An errored request causes no RAM access and no RAM change.

States:
- IDLE: `req_ready` = 1. A handshake is `req_valid & req_ready` at the rising edge (edge k). Next state depends on the request:
  - error → RESP.
  - full-width store → RAM written at edge k → RESP.
  - load → RAM read issued at edge k → LD.
  - sub-width store → RAM read issued at edge k → RMW.
- LD: at edge k+1, select the lane, extend it, register it into `rsp_rdata`, pulse `rsp_valid`, go to IDLE.
- RMW: at edge k+1, merge the store bytes into the read word, write the RAM, pulse `rsp_valid`, go to IDLE.
- RESP: terminal cycle for errors and full-width stores. Internally this collapses into the edge-k registration: `rsp_valid` is set at edge k and the state returns to IDLE at the same edge.

Request capture and response:
- The request fields (we, size, signed, addr, wdata) are captured at edge k. Inputs may change afterwards.
- The response has no backpressure. `rsp_valid` is high for exactly one cycle.

Extension:
- A byte load with `req_signed` = 1 replicates bit 7 across the upper bits. With `req_signed` = 0 the upper bits are 0.
- Half and word loads extend the same way, from bit 15 and bit 31 respectively.

## Timing
Reset:
- While `rst_n` = 0: state = IDLE, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
- `req_ready` = 1 from the first cycle after deassertion.
- RAM contents are not reset.

Latency, counted from the acceptance edge k to the cycle in which `rsp_valid` = 1:
- Error or full-width store: 1 cycle (the cycle after edge k).
- Load or sub-width store: 2 cycles (the cycle after edge k+1).

Throughput and ordering:
- `req_ready` is high again in the same cycle as `rsp_valid`, so back-to-back requests are legal.
- Throughput is 1 per cycle for full-width stores and 1 per 2 cycles otherwise.
- Accesses are strictly in order. A load accepted after a store to the same word returns the stored data; there is no hazard window.

Reset mid-operation:
- If `rst_n` falls while in LD or RMW, the access is abandoned.
- The RMW write is not performed and no `rsp_valid` is issued.
- The RAM word keeps its prior value.

Boundary behaviour:
- `req_valid` while `req_ready` = 0: the request is ignored. The requester must hold it until the handshake.
- Address equal to 2^(DEPTH_LOG2+OFF) aliases word 0.

## Test plan
- Reset then full-word store then load (DATA_WIDTH = 32):
  - Store 0xDEADBEEF to 0x10. Then load a word from 0x10.
  - Required: store `rsp_valid` 1 cycle after acceptance. Load returns 0xDEADBEEF 2 cycles after acceptance, `rsp_err` = 0.
- Sub-width store (RMW), starting from word 0xDEADBEEF at 0x10:
  - Store byte 0x5A to 0x11.
  - Then load a word from 0x10 → 0xDEAD5AEF.
  - Then store half 0x1234 to 0x12; a word load now returns 0x12345AEF.
- Extension:
  - Word 0x0000_80F0 at 0x20.
  - Load byte from 0x20: signed → 0xFFFFFFF0, unsigned → 0x000000F0.
  - Load half from 0x20 signed → 0xFFFF80F0.
- Errors:
  - Half load at 0x21 and word store at 0x22 → `rsp_err` = 1, `rsp_rdata` = 0, latency 1. A following load of 0x20 shows RAM unchanged.
  - Size 11 at DATA_WIDTH = 32 → `rsp_err` = 1.
- Reset mid-RMW:
  - Accept a byte store of 0xAA to 0x30 (word 0x11223344). Pull `rst_n` low in the RMW cycle.
  - Required: no `rsp_valid`, outputs 0. After release a load of 0x30 returns 0x11223344.
- DATA_WIDTH = 64, DEPTH_LOG2 = 4:
  - Doubleword store 0x0123456789ABCDEF to 0x08, then byte load unsigned from 0x0F → 0x01.
  - Store to 0x88 aliases 0x08 (wrap).
